// File: rtl/mult8_pkg.sv
// Shared definitions for the 8x8 sequential multiplier: widths, FSM state
// encoding and the shift codes used to position each 4x4 partial product.
package mult8_pkg;

  localparam int IN_W  = 8;
  localparam int NIB_W = 4;
  localparam int OUT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam logic [1:0] SHIFT_0 = 2'b00;
  localparam logic [1:0] SHIFT_4 = 2'b01;
  localparam logic [1:0] SHIFT_8 = 2'b10;

  // Step 0 is the low*low term, steps 1/2 are the cross terms, step 3 high*high.
  function automatic logic [1:0] shift_for_step(input logic [1:0] step);
    logic [1:0] code;
    case (step)
      2'd0:    code = SHIFT_0;
      2'd1:    code = SHIFT_4;
      2'd2:    code = SHIFT_4;
      2'd3:    code = SHIFT_8;
      default: code = SHIFT_0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/mult4x4.sv
// Combinational unsigned 4x4 -> 8-bit multiplier producing one partial product.
module mult4x4
  import mult8_pkg::*;
(
  input  logic [NIB_W-1:0]   a_i,
  input  logic [NIB_W-1:0]   b_i,
  output logic [2*NIB_W-1:0] p_o
);

  assign p_o = {4'h0, a_i} * {4'h0, b_i};

endmodule

// File: rtl/shifter.sv
// Left shifter positioning a zero-extended partial product by 0, 4 or 8 bits.
// The unused code 2'b11 yields zero so a corrupted code cannot pollute the sum.
module shifter
  import mult8_pkg::*;
(
  input  logic [OUT_W-1:0] data_i,
  input  logic [1:0]       shift_i,
  output logic [OUT_W-1:0] data_o
);

  // Select the shift amount from the code.
  always_comb begin
    data_o = 16'h0000;
    case (shift_i)
      SHIFT_0: data_o = data_i;
      SHIFT_4: data_o = data_i << 4;
      SHIFT_8: data_o = data_i << 8;
      default: data_o = 16'h0000;
    endcase
  end

endmodule

// File: rtl/mult8_seq_ctrl.sv
// Sequential 8x8 unsigned multiplier: accumulates four shifted 4x4 partial
// products over four CALC cycles, then pulses done for one cycle.
// Optional debug ports step_out/shift_cntr_out exist when MULT8_STEP_OUT_EN
// is defined.
module mult8_seq_ctrl
  import mult8_pkg::*;
#(
  parameter int unsigned CLR_ON_START = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [IN_W-1:0]  dataa,
  input  logic [IN_W-1:0]  datab,
  output logic [OUT_W-1:0] product,
  output logic             busy,
`ifdef MULT8_STEP_OUT_EN
  output logic             done,
  output logic [1:0]       step_out,
  output logic [1:0]       shift_cntr_out
`else
  output logic             done
`endif
);

  state_e             state_q, state_d;
  logic [1:0]         step_q, step_d;
  logic [IN_W-1:0]    a_q, a_d;
  logic [IN_W-1:0]    b_q, b_d;
  logic [OUT_W-1:0]   product_q, product_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [NIB_W-1:0]   a_nib_s, b_nib_s;
  logic [2*NIB_W-1:0] pp_s;
  logic [OUT_W-1:0]   pp_ext_s;
  logic [OUT_W-1:0]   shifted_s;
  logic [1:0]         shift_code_s;

  // a alternates low/high nibble every step, b moves to its high nibble at step 2.
  assign a_nib_s      = step_q[0] ? a_q[7:4] : a_q[3:0];
  assign b_nib_s      = step_q[1] ? b_q[7:4] : b_q[3:0];
  assign shift_code_s = shift_for_step(step_q);
  assign pp_ext_s     = {8'h00, pp_s};

  mult4x4 u_mult4x4 (
    .a_i (a_nib_s),
    .b_i (b_nib_s),
    .p_o (pp_s)
  );

  shifter u_shifter (
    .data_i  (pp_ext_s),
    .shift_i (shift_code_s),
    .data_o  (shifted_s)
  );

  // Next-state, operand capture and accumulation.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    a_d       = a_q;
    b_d       = b_q;
    product_d = product_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = dataa;
          b_d     = datab;
          step_d  = 2'd0;
          state_d = CALC;
          busy_d  = 1'b1;
          if (CLR_ON_START != 0) begin
            product_d = 16'h0000;
          end else begin
            product_d = product_q;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        product_d = product_q + shifted_s;
        step_d    = step_q + 2'd1;
        if (step_q == 2'd3) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = CALC;
          busy_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        step_d  = 2'd0;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      step_q    <= 2'd0;
      a_q       <= 8'h00;
      b_q       <= 8'h00;
      product_q <= 16'h0000;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      a_q       <= a_d;
      b_q       <= b_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign product = product_q;
  assign busy    = busy_q;
  assign done    = done_q;

`ifdef MULT8_STEP_OUT_EN
  assign step_out       = (state_q == CALC) ? step_q : 2'b00;
  assign shift_cntr_out = (state_q == CALC) ? shift_code_s : SHIFT_0;
`endif

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// Directed bench for mult8_seq_ctrl with an expected-product scoreboard.
module tb_mult8_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  dataa = 8'h00;
  logic [7:0]  datab = 8'h00;
  logic [15:0] product;
  logic        busy;
  logic        done;
`ifdef MULT8_STEP_OUT_EN
  logic [1:0]  step_out;
  logic [1:0]  shift_cntr_out;
`endif

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  mult8_seq_ctrl dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .dataa          (dataa),
    .datab          (datab),
    .product        (product),
    .busy           (busy),
`ifdef MULT8_STEP_OUT_EN
    .done           (done),
    .step_out       (step_out),
    .shift_cntr_out (shift_cntr_out)
`else
    .done           (done)
`endif
  );

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Pop the oldest expected product and compare against the DUT output.
  task automatic pop_chk(input string tag);
    logic [15:0] e;
    checks++;
    assert (exp_q.size() != 0) else begin
      errors++;
      $error("FAIL %s_empty observed=done expected=queued_result", tag);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk16(tag, product, e);
    end
  endtask

  // Shifted partial product for a given step, straight from the step table.
  function automatic logic [15:0] pp(input logic [7:0] a, input logic [7:0] b, input int k);
    logic [15:0] al, ah, bl, bh;
    al = {12'h000, a[3:0]};
    ah = {12'h000, a[7:4]};
    bl = {12'h000, b[3:0]};
    bh = {12'h000, b[7:4]};
    case (k)
      0:       return al * bl;
      1:       return (ah * bl) << 4;
      2:       return (al * bh) << 4;
      3:       return (ah * bh) << 8;
      default: return 16'h0000;
    endcase
  endfunction

  // One full operation: accept at edge N, check every cycle through N+5.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input string tag);
    logic [15:0] acc;
    acc = 16'h0000;
    dataa = a;
    datab = b;
    start = 1'b1;
    exp_q.push_back(16'(a) * 16'(b));
    tick;
    start = 1'b0;
    dataa = ~a;
    datab = ~b;
    chk1({tag, "_busyN"}, busy, 1'b1);
    chk1({tag, "_doneN"}, done, 1'b0);
    chk16({tag, "_clr"}, product, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      tick;
      acc = acc + pp(a, b, k);
      chk16($sformatf("%s_sum%0d", tag, k), product, acc);
      chk1($sformatf("%s_busy%0d", tag, k), busy, (k < 3));
      chk1($sformatf("%s_done%0d", tag, k), done, (k == 3));
    end
    if (done) pop_chk({tag, "_final"});
    tick;
    chk1({tag, "_done_low"}, done, 1'b0);
    chk1({tag, "_busy_low"}, busy, 1'b0);
    chk16({tag, "_hold"}, product, 16'(a) * 16'(b));
  endtask

  initial begin
    logic [7:0] ha, hb;

    #2;
    chk16("rst_product", product, 16'h0000);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    #10;
    reset_n = 1'b1;

    run_op(8'd7, 8'd9, "op7x9");
    chk16("op7x9_value", product, 16'h003F);
    run_op(8'hFF, 8'hFF, "opFFa");
    chk16("opFFa_value", product, 16'hFE01);
    run_op(8'hFF, 8'hFF, "opFFb");
    chk16("opFFb_value", product, 16'hFE01);
    run_op(8'h12, 8'h34, "op12x34");
    chk16("op12x34_value", product, 16'h03A8);
    run_op(8'h00, 8'hAB, "op0xAB");

    // Start held high with operands changing every cycle.
    start = 1'b1;
    for (int c = 0; c < 24; c++) begin
      ha = 8'(c * 7 + 3);
      hb = 8'(c * 13 + 1);
      dataa = ha;
      datab = hb;
      tick;
      if ((c % 6) == 0) exp_q.push_back(16'(ha) * 16'(hb));
      chk1($sformatf("held_busy%0d", c), busy, ((c % 6) < 4));
      chk1($sformatf("held_done%0d", c), done, ((c % 6) == 4));
      if (done) pop_chk($sformatf("held_res%0d", c));
    end
    start = 1'b0;
    chk16("held_q_empty", 16'(exp_q.size()), 16'h0000);

    // Reset in the middle of CALC while step 2 is pending.
    dataa = 8'h55;
    datab = 8'h66;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    chk16("abort_pre_sum", product, pp(8'h55, 8'h66, 0) + pp(8'h55, 8'h66, 1));
    reset_n = 1'b0;
    #1;
    chk16("abort_product", product, 16'h0000);
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_done", done, 1'b0);
    #1;
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick;
      chk1($sformatf("abort_nodone%0d", c), done, 1'b0);
      chk1($sformatf("abort_nobusy%0d", c), busy, 1'b0);
    end
    run_op(8'd3, 8'd5, "op3x5");
    chk16("op3x5_value", product, 16'h000F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
